gio_intc: RTL and testbench

Interrupt controller for the PicoBlaze GPIO port map. It collects up to eight interrupt requests, such as `int_out` lines from interrupt-on-change input ports and timer ticks, and latches their rising edges into a pending register. It arbitrates pending sources by fixed priority and drives the single PicoBlaze `interrupt`/`interrupt_ack` handshake. Mask, pending and vector registers are mapped onto port addresses; `rd_data` feeds one input of the input-port selector mux.

---
 rtl/gio_intc.sv | 151 +++++++++++++++
 tb/tb_gio_intc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gio_intc.sv
// gio_intc: edge-capturing, fixed-priority interrupt controller for the
// PicoBlaze port map, driving the single interrupt/interrupt_ack handshake.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   address         CPU port_id
//   value_in        CPU out_port data
//   wen, ren        CPU write/read strobes
//   irq_src         request lines, synchronous to clk
//   interrupt       request to CPU
//   interrupt_ack   CPU acknowledge
//   rd_data         registered read data for the input-port mux
module gio_intc #(
  parameter int          NSRC      = 4,
  parameter logic [7:0]  ADDR_MASK = 8'h10,
  parameter logic [7:0]  ADDR_PEND = 8'h11,
  parameter logic [7:0]  ADDR_VEC  = 8'h12,
  parameter logic [7:0]  ADDR_EOI  = 8'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      address,
  input  logic [7:0]      value_in,
  input  logic            wen,
  input  logic            ren,
  input  logic [NSRC-1:0] irq_src,
  output logic            interrupt,
  input  logic            interrupt_ack,
  output logic [7:0]      rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_src_d;
  logic [2:0]      r_active_id;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_id_oh;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_mask_nxt;
  logic [2:0]      w_req_id;
  logic            w_wr_mask;
  logic            w_wr_pend;
  logic            w_wr_eoi;
  logic            w_eoi_clr;
  logic            w_rd_hit;
  logic [7:0]      w_rd_val;
  logic [7:0]      w_mask8;
  logic [7:0]      w_pend8;
  logic            w_unused;

  // value_in bits above NSRC are don't-care for every register
  assign w_unused  = &{1'b0, value_in};

  assign w_edge    = irq_src & ~r_src_d;
  assign w_req     = r_pend & r_mask;
  assign w_wr_mask = wen && (address == ADDR_MASK);
  assign w_wr_pend = wen && (address == ADDR_PEND);
  assign w_wr_eoi  = wen && (address == ADDR_EOI);
  assign w_eoi_clr = w_wr_eoi && (r_state == SERVICE);

  always_comb begin
    w_id_oh = '0;
    for (int i = 0; i < NSRC; i++)
      w_id_oh[i] = (r_active_id == 3'(i));
  end

  // Clears first, then new edges: a same-cycle edge wins over any clear
  assign w_clr = (w_wr_pend ? value_in[NSRC-1:0] : '0)
               | (w_eoi_clr ? w_id_oh : '0);
  assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;
  assign w_mask_nxt = w_wr_mask ? value_in[NSRC-1:0] : r_mask;

  // Scan high to low so the lowest index ends up selected
  always_comb begin
    w_req_id = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (w_req[i])
        w_req_id = 3'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (|w_req)
          w_state_nxt = ASSERT;
      ASSERT:
        if (interrupt_ack)
          w_state_nxt = SERVICE;
        else if (~|(w_id_oh & w_mask_nxt & w_pend_nxt))
          w_state_nxt = IDLE;
      SERVICE:
        if (w_wr_eoi)
          w_state_nxt = IDLE;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_mask8 = '0;
    w_pend8 = '0;
    w_mask8[NSRC-1:0] = r_mask;
    w_pend8[NSRC-1:0] = r_pend;
  end

  always_comb begin
    w_rd_hit = 1'b1;
    w_rd_val = rd_data;
    unique case (1'b1)
      (address == ADDR_MASK): w_rd_val = w_mask8;
      (address == ADDR_PEND): w_rd_val = w_pend8;
      (address == ADDR_VEC):
        w_rd_val = {(r_state != IDLE), 4'b0, r_active_id};
      default: w_rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_pend      <= '0;
      r_src_d     <= '0;
      r_active_id <= '0;
      interrupt   <= 1'b0;
      rd_data     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_pend    <= w_pend_nxt;
      r_src_d   <= irq_src;
      interrupt <= (w_state_nxt == ASSERT);
      if ((r_state == IDLE) && (|w_req))
        r_active_id <= w_req_id;
      if (ren && w_rd_hit)
        rd_data <= w_rd_val;
    end
  end

endmodule

// File: tb/tb_gio_intc.sv
// tb_gio_intc: scenario tasks for gio_intc; read results are
// queued as expectations at issue and popped when rd_data lands.
module tb_gio_intc;

  localparam logic [7:0] A_MASK = 8'h10;
  localparam logic [7:0] A_PEND = 8'h11;
  localparam logic [7:0] A_VEC  = 8'h12;
  localparam logic [7:0] A_EOI  = 8'h13;

  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] address = 0;
  logic [7:0] value_in = 0;
  logic       wen = 0;
  logic       ren = 0;
  logic [3:0] irq_src = 0;
  logic       interrupt;
  logic       interrupt_ack = 0;
  logic [7:0] rd_data;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] d, e;
  bit ok;

  gio_intc #(.NSRC(4)) dut (
    .clk(clk), .rst(rst), .address(address),
    .value_in(value_in), .wen(wen), .ren(ren),
    .irq_src(irq_src), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] v);
    address = a; value_in = v; wen = 1;
    tick();
    wen = 0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] r);
    address = a; ren = 1;
    tick();
    ren = 0;
    r = rd_data;
  endtask

  task automatic pulse(input logic [3:0] s);
    irq_src = s;
    tick();
    irq_src = 0;
  endtask

  task automatic ack();
    interrupt_ack = 1;
    tick();
    interrupt_ack = 0;
  endtask

  task automatic wait_int(output bit got);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (interrupt === 1'b1) got = 1;
      else tick();
    end
  endtask

  task automatic rd_check(input string nm, input logic [7:0] a,
                          input logic [7:0] x);
    exp_q.push_back(x);
    cpu_read(a, d);
    e = exp_q.pop_front();
    n_total++;
    if (d !== e) $display("FAIL %s got %h exp %h", nm, d, e);
    else n_pass++;
  endtask

  task automatic int_check(input string nm, input logic x);
    n_total++;
    if (interrupt !== x)
      $display("FAIL %s interrupt got %b exp %b", nm, interrupt, x);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    int_check("rst_int", 1'b0);
    n_total++;
    if (rd_data !== 8'h00) $display("FAIL rst_rd got %h exp 00", rd_data);
    else n_pass++;
    rd_check("rst_mask", A_MASK, 8'h00);
    rd_check("rst_pend", A_PEND, 8'h00);
    rd_check("rst_vec", A_VEC, 8'h00);
  endtask

  task automatic test_basic();
    cpu_write(A_MASK, 8'h01);
    pulse(4'b0001);
    int_check("basic_e0", 1'b0);
    tick();
    int_check("basic_e1", 1'b1);
    ack();
    int_check("basic_ack", 1'b0);
    rd_check("basic_vec_svc", A_VEC, 8'h80);
    cpu_write(A_EOI, 8'h5a);
    rd_check("basic_pend_eoi", A_PEND, 8'h00);
    rd_check("basic_vec_eoi", A_VEC, 8'h00);
  endtask

  task automatic test_priority();
    cpu_write(A_MASK, 8'h0f);
    pulse(4'b1010);
    wait_int(ok);
    n_total++;
    if (!ok) $display("FAIL prio_first timeout got 0 exp 1");
    else n_pass++;
    ack();
    rd_check("prio_vec1", A_VEC, 8'h81);
    cpu_write(A_EOI, 8'h00);
    int_check("prio_gap", 1'b0);
    tick();
    int_check("prio_second", 1'b1);
    ack();
    rd_check("prio_vec2", A_VEC, 8'h83);
    cpu_write(A_EOI, 8'h00);
    rd_check("prio_pend_end", A_PEND, 8'h00);
  endtask

  task automatic test_masked();
    cpu_write(A_MASK, 8'h00);
    pulse(4'b0100);
    tick(); tick();
    int_check("mask_none", 1'b0);
    rd_check("mask_pend", A_PEND, 8'h04);
    cpu_write(A_MASK, 8'h04);
    int_check("mask_w0", 1'b0);
    tick();
    int_check("mask_rise", 1'b1);
    cpu_write(A_PEND, 8'h04);
    int_check("mask_cancel", 1'b0);
    rd_check("mask_vec_idle", A_VEC, 8'h02);
    rd_check("mask_pend_clr", A_PEND, 8'h00);
    tick(); tick();
    int_check("mask_stay_low", 1'b0);
  endtask

  task automatic test_back_to_back();
    cpu_write(A_MASK, 8'h01);
    pulse(4'b0001);
    wait_int(ok);
    n_total++;
    if (!ok) $display("FAIL retrig_first timeout got 0 exp 1");
    else n_pass++;
    ack();
    irq_src = 4'b0001;
    cpu_write(A_EOI, 8'h00);
    irq_src = 0;
    int_check("retrig_low", 1'b0);
    tick();
    int_check("retrig_reassert", 1'b1);
    rd_check("retrig_pend", A_PEND, 8'h01);
    ack();
    cpu_write(A_EOI, 8'h00);
    rd_check("retrig_pend_end", A_PEND, 8'h00);
  endtask

  task automatic test_ignored_and_reset();
    cpu_write(A_MASK, 8'h00);
    pulse(4'b0010);
    cpu_write(A_EOI, 8'h00);
    rd_check("ign_eoi_pend", A_PEND, 8'h02);
    ack();
    int_check("ign_ack_int", 1'b0);
    rd_check("ign_ack_vec", A_VEC, 8'h00);
    cpu_write(A_PEND, 8'hff);
    cpu_write(A_MASK, 8'h01);
    pulse(4'b0001);
    wait_int(ok);
    n_total++;
    if (!ok) $display("FAIL rst_pre timeout got 0 exp 1");
    else n_pass++;
    rd_check("rst_pre_mask", A_MASK, 8'h01);
    rst = 1; tick(); rst = 0;
    int_check("rst_mid_int", 1'b0);
    n_total++;
    if (rd_data !== 8'h00) $display("FAIL rst_mid_rd got %h exp 00", rd_data);
    else n_pass++;
    rd_check("rst_mid_mask", A_MASK, 8'h00);
    rd_check("rst_mid_pend", A_PEND, 8'h00);
    cpu_write(A_MASK, 8'h01);
    tick(); tick(); tick();
    int_check("rst_no_edge", 1'b0);
    pulse(4'b0001);
    tick();
    int_check("rst_new_edge", 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_masked();
    test_back_to_back();
    test_ignored_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
